// File: rtl/regfile_multiply_unit.sv
// regfile_multiply_unit
// Iterative shift-add multiplier placed between the register file read ports
// and its write port. One bit of the multiplier is retired per cycle, so a
// WIDTH x WIDTH product takes WIDTH RUN cycles. The unit returns either the
// low word (MUL) or the high word (UMULH) of the 2*WIDTH product.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request a multiply; only sampled while idle
//   operand_a    multiplicand (register file read port A)
//   operand_b    multiplier   (register file read port B)
//   dest_in      destination register of the product
//   high_select  0 = low word (MUL), 1 = high word (UMULH)
//   busy         multiply in progress, including the completion cycle
//   done         one-cycle completion pulse
//   result       product word to the register file data input
//   address      destination to the register file write address
//   write        one-cycle write strobe; suppressed for the zero register
module regfile_multiply_unit #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 31
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  input  logic [ADDR_WIDTH-1:0] dest_in,
  input  logic                  high_select,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write
);

  localparam int unsigned CNT_WIDTH = $clog2(WIDTH);
  localparam int unsigned PROD_WIDTH = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state, state_d;
  logic [WIDTH-1:0]        mcand, mcand_d;
  logic [PROD_WIDTH-1:0]   prod, prod_d;
  logic [CNT_WIDTH-1:0]    cnt, cnt_d;
  logic [ADDR_WIDTH-1:0]   dest, dest_d;
  logic                    hsel, hsel_d;
  logic                    busy_d, done_d, write_d;
  logic [WIDTH-1:0]        result_d;
  logic [ADDR_WIDTH-1:0]   address_d;

  logic [WIDTH:0]          addend;
  logic [WIDTH:0]          sum;
  logic [PROD_WIDTH-1:0]   prod_step;

  // One shift-add iteration: conditional add into the upper half, then shift
  // {carry, P} right by one. The carry lands in the top product bit.
  always_comb begin
    addend    = prod[0] ? {1'b0, mcand} : '0;
    sum       = {1'b0, prod[PROD_WIDTH-1:WIDTH]} + addend;
    prod_step = {sum, prod[WIDTH-1:1]};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state;
    mcand_d   = mcand;
    prod_d    = prod;
    cnt_d     = cnt;
    dest_d    = dest;
    hsel_d    = hsel;
    busy_d    = busy;
    done_d    = 1'b0;
    write_d   = 1'b0;
    result_d  = result;
    address_d = address;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mcand_d = operand_a;
          dest_d  = dest_in;
          hsel_d  = high_select;
          prod_d  = {{WIDTH{1'b0}}, operand_b};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d = prod_step;
        cnt_d  = cnt + CNT_WIDTH'(1);
        // Final iteration: outputs are taken from the freshly computed step
        // so they are valid in the cycle the state reads DONE.
        if (cnt == CNT_WIDTH'(WIDTH - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          write_d   = (dest != ADDR_WIDTH'(ZERO_REG));
          result_d  = hsel ? prod_step[PROD_WIDTH-1:WIDTH] : prod_step[WIDTH-1:0];
          address_d = dest;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      prod    <= '0;
      cnt     <= '0;
      dest    <= '0;
      hsel    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      write   <= 1'b0;
      result  <= '0;
      address <= '0;
    end else begin
      state   <= state_d;
      mcand   <= mcand_d;
      prod    <= prod_d;
      cnt     <= cnt_d;
      dest    <= dest_d;
      hsel    <= hsel_d;
      busy    <= busy_d;
      done    <= done_d;
      write   <= write_d;
      result  <= result_d;
      address <= address_d;
    end
  end

endmodule

// File: tb/tb_regfile_multiply_unit.sv
module tb_regfile_multiply_unit;

  localparam int unsigned W  = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned LAT = 64;

  logic          clock;
  logic          reset;
  logic          start;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [AW-1:0] dest_in;
  logic          high_select;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [AW-1:0] address;
  logic          write;

  regfile_multiply_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .dest_in     (dest_in),
    .high_select (high_select),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .address     (address),
    .write       (write)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [W-1:0]  res;
    logic [AW-1:0] addr;
    logic          wr;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: full 128-bit product by plain arithmetic.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [AW-1:0] d, input logic hs, input int due);
    exp_t e;
    logic [2*W-1:0] full;
    full   = (2*W)'(a) * (2*W)'(b);
    e.res  = hs ? full[2*W-1:W] : full[W-1:0];
    e.addr = d;
    e.wr   = (d != AW'(31));
    e.due  = due;
    return e;
  endfunction

  // Monitor: compare every completion against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (write && !done) check("write_without_done", 64'(write), 64'(0));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("address", 64'(address), 64'(e.addr));
          check("write", 64'(write), 64'(e.wr));
          check("latency", 64'(cyc), 64'(e.due));
          check("busy_in_done", 64'(busy), 64'(1));
        end
      end
    end
  end

  // Issue one multiply; operands are scrambled right after acceptance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] d, input logic hs);
    @(negedge clock);
    operand_a = a; operand_b = b; dest_in = d; high_select = hs; start = 1'b1;
    @(posedge clock);
    #1;
    exp_q.push_back(model(a, b, d, hs, cyc + int'(LAT)));
    start = 1'b0;
    operand_a = {$urandom, $urandom};
    operand_b = {$urandom, $urandom};
    dest_in = AW'($urandom);
    high_select = ~hs;
    check("busy_after_start", 64'(busy), 64'(1));
  endtask

  // Wait for done (bounded), then expect idle on the following cycle.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 80) begin
      @(negedge clock);
      n++;
    end
    if (!done) check("done_timeout", 64'(done), 64'(1));
    @(negedge clock);
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_pulse_width", 64'(done), 64'(0));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [AW-1:0] d, input logic hs);
    issue(a, b, d, hs);
    wait_done();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; operand_a = '0; operand_b = '0;
    dest_in = '0; high_select = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_write", 64'(write), 64'(0));
    check("rst_result", result, 64'(0));
    check("rst_address", 64'(address), 64'(0));
    // Start during reset must be ignored.
    start = 1'b1; operand_a = 64'd1; operand_b = 64'd1;
    @(posedge clock); #1;
    check("start_in_reset", 64'(busy), 64'(0));
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check("idle_after_reset", 64'(busy), 64'(0));

    run_op(64'd3, 64'd5, 5'd4, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'd4, 5'd7, 1'b1);
    run_op(64'h8000_0000_0000_0000, 64'd4, 5'd7, 1'b0);
    run_op('1, '1, 5'd1, 1'b0);
    run_op('1, '1, 5'd2, 1'b1);
    run_op(64'd6, 64'd7, 5'd31, 1'b0);
    run_op(64'd0, 64'h1234, 5'd9, 1'b0);

    // A second start while busy is dropped.
    issue(64'd2, 64'd9, 5'd3, 1'b0);
    repeat (9) @(negedge clock);
    operand_a = 64'd100; operand_b = 64'd100; dest_in = 5'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    repeat (70) @(negedge clock);
    check("no_queued_start", 64'(exp_q.size()), 64'(0));

    // Reset mid-operation aborts without a write.
    issue(64'd11, 64'd13, 5'd6, 1'b0);
    repeat (30) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_write", 64'(write), 64'(0));
    check("abort_result", result, 64'(0));
    check("abort_address", 64'(address), 64'(0));
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (70) @(negedge clock);
    run_op(64'd10, 64'd10, 5'd12, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, AW'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
